// File: rtl/button_port_pkg.sv
// Shared types and constants for the pushbutton input port.
// Optional auto-repeat is selected by defining BUTTON_PORT_AUTOREPEAT_EN (undefined by default).
package button_port_pkg;

  localparam int BTN_W = 4;

  typedef logic [BTN_W-1:0] btn_t;

  localparam btn_t BTN_RST = '0;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, whole-nibble debouncer and press-event detector for the pushbuttons.
// With BUTTON_PORT_AUTOREPEAT_EN defined, a held nonzero value also emits periodic repeat events.
module btn_debounce
  import button_port_pkg::*;
#(
  parameter int DEB_CYCLES    = 16
`ifdef BUTTON_PORT_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES = 256
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [BTN_W-1:0] raw_buttons,
  output logic [BTN_W-1:0] deb_val,
  output logic             press_evt
);

  localparam int            DW       = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  btn_t          sync1, sync2;
  logic [DW-1:0] deb_cnt;
  logic          stable, accept, new_press, push_now;

  // sync1 is the next sample, so the stability count starts the cycle a change reaches sync2.
  assign stable    = (sync1 == sync2);
  assign accept    = stable && (deb_cnt == DEB_LAST) && (sync2 != deb_val);
  assign new_press = accept && (sync2 != BTN_RST);

`ifdef BUTTON_PORT_AUTOREPEAT_EN
  localparam int            RW       = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_fire;

  assign rpt_fire = !accept && (deb_val != BTN_RST) && (rpt_cnt == RPT_LAST);
  assign push_now = new_press || rpt_fire;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rpt_cnt <= '0;
    end else if (accept || (deb_val == BTN_RST) || rpt_fire) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  assign push_now = new_press;
`endif

  // NOTE: non-blocking assignments let sync1 -> sync2 shift one stage per clock instead of collapsing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1     <= BTN_RST;
      sync2     <= BTN_RST;
      deb_cnt   <= '0;
      deb_val   <= BTN_RST;
      press_evt <= 1'b0;
    end else begin
      sync1     <= raw_buttons;
      sync2     <= sync1;
      press_evt <= push_now;
      if (!stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_LAST) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      if (accept) begin
        deb_val <= sync2;
      end
    end
  end

endmodule

// File: rtl/button_port.sv
// Pushbutton input port: debounced press nibbles are queued in a FIFO whose head feeds the uP.
// Auto-repeat of held buttons is compiled in when BUTTON_PORT_AUTOREPEAT_EN is defined.
module button_port
  import button_port_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int DEB_CYCLES    = 16,
  parameter int REPEAT_CYCLES = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [BTN_W-1:0] raw_buttons,
  input  logic             rd_strobe,
  input  logic             clr_ovf,
  output logic [BTN_W-1:0] pushbuttons,
  output logic             data_valid,
  output logic             fifo_full,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("button_port: DEPTH must be a power of two in 2..16");
  end
  if (DEB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_timing
    $error("button_port: DEB_CYCLES and REPEAT_CYCLES must be at least 2");
  end

  btn_t          deb_val;
  logic          press_evt;
  btn_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, do_push, do_pop;

  btn_debounce #(
    .DEB_CYCLES    (DEB_CYCLES)
`ifdef BUTTON_PORT_AUTOREPEAT_EN
    ,
    .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
  ) u_debounce (
    .clock       (clock),
    .reset       (reset),
    .raw_buttons (raw_buttons),
    .deb_val     (deb_val),
    .press_evt   (press_evt)
  );

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept the push.
  assign do_push = press_evt && (!full || rd_strobe);
  assign do_pop  = rd_strobe && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
      if (press_evt && full && !rd_strobe) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // NOTE: storage has no reset; count gates every read, so stale entries are never visible.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= deb_val;
    end
  end

  assign pushbuttons = empty ? BTN_RST : mem[rd_ptr];
  assign data_valid  = !empty;
  assign fifo_full   = full;

endmodule

// File: tb/tb_button_port.sv
// Directed self-checking bench for button_port (DEPTH=4, DEB_CYCLES=16, REPEAT_CYCLES=64).
// Expected auto-repeat count follows BUTTON_PORT_AUTOREPEAT_EN.
module tb_button_port;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] raw_buttons = 4'b0000;
  logic       rd_strobe = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [3:0] pushbuttons;
  logic       data_valid;
  logic       fifo_full;
  logic       overflow;

  int checks = 0;
  int errors = 0;

`ifdef BUTTON_PORT_AUTOREPEAT_EN
  localparam int EXP_HELD = 4;
`else
  localparam int EXP_HELD = 1;
`endif

  button_port #(
    .DEPTH         (4),
    .DEB_CYCLES    (16),
    .REPEAT_CYCLES (64)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .raw_buttons (raw_buttons),
    .rd_strobe   (rd_strobe),
    .clr_ovf     (clr_ovf),
    .pushbuttons (pushbuttons),
    .data_valid  (data_valid),
    .fifo_full   (fifo_full),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] pb, input logic dv,
                           input logic ff, input logic ov);
    check({tag, ".pb"}, {4'b0, pushbuttons}, {4'b0, pb});
    check({tag, ".dv"}, {7'b0, data_valid}, {7'b0, dv});
    check({tag, ".ff"}, {7'b0, fifo_full}, {7'b0, ff});
    check({tag, ".ov"}, {7'b0, overflow}, {7'b0, ov});
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pop();
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
  endtask

  task automatic press(input logic [3:0] v);
    raw_buttons = v;
    tick(24);
    raw_buttons = 4'b0000;
    tick(24);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // T1: reset held with toggling pins, then release with 1111 stable.
    for (int i = 0; i < 4; i++) begin
      raw_buttons = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      tick();
      check_out("t1_hold", 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    raw_buttons = 4'b1111;
    reset = 1'b1;
    tick(18);
    check_out("t1_pre", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("t1_post", 4'b1111, 1'b1, 1'b0, 1'b0);
    pop();
    raw_buttons = 4'b0000;
    tick(24);
    check("t1_release", {7'b0, data_valid}, 8'h00);

    // T2: clean press, exact 19-cycle latency, then a single read empties the FIFO.
    raw_buttons = 4'b0101;
    tick(18);
    check("t2_lat18", {7'b0, data_valid}, 8'h00);
    tick();
    check_out("t2_lat19", 4'b0101, 1'b1, 1'b0, 1'b0);
    tick(5);
    pop();
    check_out("t2_read", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(5);
    raw_buttons = 4'b0000;
    tick(24);
    check("t2_release", {7'b0, data_valid}, 8'h00);

    // T3: bouncing contact settles into exactly one entry.
    for (int i = 0; i < 12; i++) begin
      raw_buttons = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(5);
    end
    check("t3_bounce", {7'b0, data_valid}, 8'h00);
    raw_buttons = 4'b0010;
    tick(25);
    check_out("t3_one", 4'b0010, 1'b1, 1'b0, 1'b0);
    pop();
    check("t3_empty", {7'b0, data_valid}, 8'h00);
    raw_buttons = 4'b0000;
    tick(24);

    // T4: five presses into four slots, drain in order, clear the sticky flag.
    press(4'b0001);
    press(4'b0010);
    press(4'b0011);
    press(4'b0100);
    check_out("t4_full", 4'b0001, 1'b1, 1'b1, 1'b0);
    press(4'b1000);
    check_out("t4_ovf", 4'b0001, 1'b1, 1'b1, 1'b1);
    pop();
    check("t4_pop1", {4'b0, pushbuttons}, 8'h02);
    pop();
    check("t4_pop2", {4'b0, pushbuttons}, 8'h03);
    pop();
    check("t4_pop3", {4'b0, pushbuttons}, 8'h04);
    pop();
    check_out("t4_drained", 4'b0000, 1'b0, 1'b0, 1'b1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t4_clr", {7'b0, overflow}, 8'h00);

    // T5: push and pop in the same cycle on a full FIFO, then pop on empty.
    press(4'b0001);
    press(4'b0010);
    press(4'b0011);
    press(4'b0100);
    raw_buttons = 4'b0110;
    tick(18);
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    check_out("t5_simul", 4'b0010, 1'b1, 1'b1, 1'b0);
    raw_buttons = 4'b0000;
    tick(24);
    pop();
    check("t5_h3", {4'b0, pushbuttons}, 8'h03);
    pop();
    check("t5_h4", {4'b0, pushbuttons}, 8'h04);
    pop();
    check("t5_tail", {4'b0, pushbuttons}, 8'h06);
    pop();
    check_out("t5_empty", 4'b0000, 1'b0, 1'b0, 1'b0);
    pop();
    check_out("t5_pop_empty", 4'b0000, 1'b0, 1'b0, 1'b0);
    press(4'b1001);
    check_out("t5_after", 4'b1001, 1'b1, 1'b0, 1'b0);
    pop();

    // Asynchronous reset mid-operation clears everything without a clock edge.
    press(4'b0101);
    press(4'b1010);
    check("rst_pre", {7'b0, data_valid}, 8'h01);
    reset = 1'b0;
    #1;
    check_out("rst_async", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick(2);
    reset = 1'b1;
    tick(24);
    check("rst_after", {7'b0, data_valid}, 8'h00);

    // T6: hold 1000 for 200 cycles after the press event.
    raw_buttons = 4'b1000;
    tick(19);
    tick(200);
    raw_buttons = 4'b0000;
    tick(24);
    check("t6_ovf", {7'b0, overflow}, 8'h00);
    for (int i = 0; i < EXP_HELD; i++) begin
      check("t6_entry", {3'b0, data_valid, pushbuttons}, 8'h18);
      pop();
    end
    check("t6_count", {7'b0, data_valid}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
